// File: rtl/vga_plot_sink.sv
// Plot-interface sink: captures (x, y, colour) plots into a WIDTHxHEIGHT 3-bit framebuffer,
// with a 1-cycle readback port, a full-screen clear engine, a plot counter and a sticky OOB flag.
module vga_plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clr_req,
    input  logic [2:0]  clr_colour,
    output logic        busy,
    input  logic        rd_req,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic [15:0] plot_count,
    output logic        oob,
    input  logic        oob_clr,
    output logic [0:0]  fsm_state
);

    localparam int          DEPTH = WIDTH * HEIGHT;
    localparam logic [14:0] LAST  = 15'(DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // Handshake: a plot is accepted on any rising edge where vga_plot=1, busy=0 and the
    // coordinate is in range; rd_req=1 in cycle N yields rd_valid=1 with data in cycle N+1.

    logic [2:0]  mem [0:DEPTH-1];
    logic [0:0]  state;
    logic [14:0] ptr;
    logic [2:0]  fill;

    logic        plot_in_range;
    logic        rd_in_range;
    logic [14:0] plot_addr;
    logic [14:0] rd_addr;
    logic        plot_ok;
    logic        plot_bad;
    logic        clear_done;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;

    assign busy      = (state == S_CLEAR);
    assign fsm_state = state;

    assign plot_in_range = ({24'd0, vga_x} < 32'(WIDTH)) && ({25'd0, vga_y} < 32'(HEIGHT));
    assign rd_in_range   = ({24'd0, rd_x} < 32'(WIDTH)) && ({25'd0, rd_y} < 32'(HEIGHT));
    assign plot_addr     = {8'd0, vga_y} * 15'(WIDTH) + {7'd0, vga_x};
    // Out-of-range reads never index the array; they return zero instead.
    assign rd_addr       = rd_in_range ? ({8'd0, rd_y} * 15'(WIDTH) + {7'd0, rd_x}) : 15'd0;

    assign plot_ok    = vga_plot && !busy && plot_in_range;
    assign plot_bad   = vga_plot && !busy && !plot_in_range;
    assign clear_done = (state == S_CLEAR) && (ptr == LAST);

    // Only one writer is ever active: plots are blocked while the clear engine owns the port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = plot_addr;
        wr_data = vga_colour;
        if (state == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = ptr;
            wr_data = fill;
        end else if (plot_ok) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write to the same address is not visible.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_colour <= 3'd0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_colour <= rd_in_range ? mem[rd_addr] : 3'd0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= 15'd0;
            fill  <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state <= S_CLEAR;
                        fill  <= clr_colour;
                        ptr   <= 15'd0;
                    end
                end
                S_CLEAR: begin
                    if (ptr == LAST) begin
                        state <= S_IDLE;
                        ptr   <= 15'd0;
                    end else begin
                        ptr <= ptr + 15'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= 16'd0;
        end else if (clear_done) begin
            plot_count <= 16'd0;
        end else if (plot_ok && (plot_count != 16'hFFFF)) begin
            plot_count <= plot_count + 16'd1;
        end
    end

    // A new out-of-range plot wins over a same-cycle clear request.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            oob <= 1'b0;
        end else if (plot_bad) begin
            oob <= 1'b1;
        end else if (oob_clr) begin
            oob <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: directed plots, clears and reads; read data is checked by a
// monitor against an expected queue filled when each read is issued.
module tb_vga_plot_sink;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clr_req;
    logic [2:0]  clr_colour;
    logic        busy;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic [15:0] plot_count;
    logic        oob;
    logic        oob_clr;
    logic [0:0]  fsm_state;

    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    vga_plot_sink #(.WIDTH(160), .HEIGHT(120)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clr_req    (clr_req),
        .clr_colour (clr_colour),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .plot_count (plot_count),
        .oob        (oob),
        .oob_clr    (oob_clr),
        .fsm_state  (fsm_state)
    );

    // Clock / reset
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every rd_valid pops one expected colour
    always @(negedge CLOCK_50) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", {15'd0, rd_valid}, 16'd0);
            end else begin
                check("rd_colour", {13'd0, rd_colour}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks: called at a negedge, return at the next negedge
    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic plot(input int x, input int y, input logic [2:0] c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic rd(input int x, input int y, input logic [2:0] exp);
        rd_x = 8'(x); rd_y = 7'(y); rd_req = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic start_clear(input logic [2:0] c);
        clr_colour = c; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clr_req = 1'b0; clr_colour = '0; rd_req = 1'b0; rd_x = '0; rd_y = '0; oob_clr = 1'b0;
        tick(); tick();
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_rd_valid", {15'd0, rd_valid}, 16'd0);
        check("rst_rd_colour", {13'd0, rd_colour}, 16'd0);
        check("rst_plot_count", plot_count, 16'd0);
        check("rst_oob", {15'd0, oob}, 16'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic plot and readback
        plot(5, 7, 3'b101);
        rd(5, 7, 3'b101);
        check("t1_count", plot_count, 16'd1);

        // 2: out-of-range plots and the sticky flag
        plot(160, 0, 3'b001);
        check("t2_oob_x", {15'd0, oob}, 16'd1);
        plot(0, 120, 3'b010);
        check("t2_oob_y", {15'd0, oob}, 16'd1);
        check("t2_count", plot_count, 16'd1);
        rd(160, 0, 3'b000);
        rd(5, 7, 3'b101);
        oob_clr = 1'b1; tick(); oob_clr = 1'b0;
        check("t2_oob_clr", {15'd0, oob}, 16'd0);
        oob_clr = 1'b1; plot(200, 3, 3'b011); oob_clr = 1'b0;
        check("t2_set_wins", {15'd0, oob}, 16'd1);
        oob_clr = 1'b1; tick(); oob_clr = 1'b0;
        check("t2_oob_clr2", {15'd0, oob}, 16'd0);

        // 3: full clear, with a same-cycle plot that the clear overwrites
        vga_x = 8'd20; vga_y = 7'd20; vga_colour = 3'b111; vga_plot = 1'b1;
        start_clear(3'b010);
        vga_plot = 1'b0;
        check("t3_busy_start", {15'd0, busy}, 16'd1);
        check("t3_count_pre", plot_count, 16'd2);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'b110;
            vga_plot = (n >= 10 && n < 20) || (n >= 19195);
            clr_req = (n == 60); clr_colour = 3'b101;
            rd_x = 8'd0; rd_y = 7'd0; rd_req = (n == 50);
            if (n == 50) exp_q.push_back(3'b010);
            if (n == 100) check("t3_count_busy", plot_count, 16'd2);
            if (n == 100) check("t3_oob_busy", {15'd0, oob}, 16'd0);
            tick();
            n++;
        end
        vga_plot = 1'b0; clr_req = 1'b0; rd_req = 1'b0;
        check("t3_busy_cycles", 16'(n), 16'd19200);
        check("t3_count_post", plot_count, 16'd0);
        rd(159, 119, 3'b010);
        rd(0, 0, 3'b010);
        rd(20, 20, 3'b010);

        // 4: read-before-write and back-to-back reads
        plot(10, 10, 3'b001);
        vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'b111; vga_plot = 1'b1;
        rd(10, 10, 3'b001);
        vga_plot = 1'b0;
        rd(10, 10, 3'b111);
        rd(159, 119, 3'b010);
        rd(5, 7, 3'b010);
        check("t4_count", plot_count, 16'd2);

        // 5: plot counter saturation
        vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'b100; vga_plot = 1'b1;
        for (int i = 0; i < 65532; i++) tick();
        check("t5_count_fffe", plot_count, 16'hFFFE);
        tick();
        check("t5_count_ffff", plot_count, 16'hFFFF);
        tick(); tick(); tick();
        vga_plot = 1'b0;
        check("t5_count_sat", plot_count, 16'hFFFF);
        rd(1, 1, 3'b100);

        // 6: reset in the middle of a clear
        start_clear(3'b110);
        for (int i = 0; i < 1000; i++) tick();
        check("t6_busy_pre", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy_async", {15'd0, busy}, 16'd0);
        check("t6_count_async", plot_count, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(0, 0, 3'b110);
        rd(20, 3, 3'b110);
        rd(39, 6, 3'b110);
        rd(40, 6, 3'b010);
        rd(1, 1, 3'b110);
        start_clear(3'b011);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd(0, 0, 3'b011);
        rd(1, 0, 3'b011);
        rd(2, 0, 3'b110);

        tick(); tick(); tick();
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
